// File: rtl/cpu_pipe_pkg.sv
// Shared types and defaults for the pipeline stage registers of the 5-stage core.
package cpu_pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEST_W_DEF = 4;

  // Number of control bits (wb_en, mem_r_en) at the top of a packed MEM->WB payload.
  localparam int MEM_WB_CTRL_W = 2;

  // One MEM->WB beat at the default widths; field order matches the packed payload vector.
  typedef struct packed {
    logic                  wb_en;
    logic                  mem_r_en;
    logic [DATA_W_DEF-1:0] alu_result;
    logic [DATA_W_DEF-1:0] mem_rd_data;
    logic [DATA_W_DEF-1:0] pc;
    logic [DATA_W_DEF-1:0] instr;
    logic [DEST_W_DEF-1:0] dest;
  } mem_wb_payload_t;

  // Width of a packed MEM->WB payload for arbitrary data/destination widths.
  function automatic int mem_wb_payload_w(input int data_w, input int dest_w);
    return MEM_WB_CTRL_W + 4 * data_w + dest_w;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: a valid bit plus a payload register.
// The top CTRL_W payload bits are control strobes; they are zeroed whenever the
// slot goes empty so an empty slot never presents an active strobe.
module pipe_slot #(
  parameter int W      = 8,
  parameter int CTRL_W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  // Slot state: flush beats load, load beats clear; data bits survive flush/clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the payload is reset too (not just valid) so every output reads 0 out of reset;
      // state is written with <= so all slots update from the same pre-edge values.
      valid <= 1'b0;
      q     <= '0;
    end else if (flush) begin
      valid               <= 1'b0;
      q[W-1 -: CTRL_W]    <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (clear) begin
      valid               <= 1'b0;
      q[W-1 -: CTRL_W]    <= '0;
    end
  end

endmodule

// File: rtl/mem_wb_pipe_stage.sv
// MEM->WB pipeline stage register with valid/ready handshake, synchronous flush
// and a saturating stall counter.
// Define MEM_WB_SKID_EN to add a 1-entry skid buffer: in_ready then comes
// straight from a flop and has no combinational path from out_ready.
module mem_wb_pipe_stage
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEST_W  = DEST_W_DEF,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_wb_en,
  input  logic               in_mem_r_en,
  input  logic [DATA_W-1:0]  in_alu_result,
  input  logic [DATA_W-1:0]  in_mem_rd_data,
  input  logic [DATA_W-1:0]  in_pc,
  input  logic [DATA_W-1:0]  in_instr,
  input  logic [DEST_W-1:0]  in_dest,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_wb_en,
  output logic               out_mem_r_en,
  output logic [DATA_W-1:0]  out_alu_result,
  output logic [DATA_W-1:0]  out_mem_rd_data,
  output logic [DATA_W-1:0]  out_pc,
  output logic [DATA_W-1:0]  out_instr,
  output logic [DEST_W-1:0]  out_dest,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam int PAY_W = mem_wb_payload_w(DATA_W, DEST_W);

  logic [PAY_W-1:0] in_pay;
  logic [PAY_W-1:0] main_d;
  logic [PAY_W-1:0] main_q;
  logic             main_valid;
  logic             main_load;
  logic             main_free;
  logic             accept;

  assign in_pay    = {in_wb_en, in_mem_r_en, in_alu_result, in_mem_rd_data,
                      in_pc, in_instr, in_dest};
  assign main_free = !main_valid || out_ready;
  assign accept    = in_valid && in_ready;

`ifdef MEM_WB_SKID_EN
  logic [PAY_W-1:0] skid_q;
  logic             skid_valid;
  logic             skid_load;
  logic             skid_clear;

  // A held skid beat is older than anything on the input, so it refills main first.
  // While the skid is full in_ready is low, so accept and skid_valid are exclusive.
  assign in_ready   = !skid_valid;
  assign main_load  = main_free && (skid_valid || accept);
  assign main_d     = skid_valid ? skid_q : in_pay;
  assign skid_load  = accept && !main_free;
  assign skid_clear = main_free && skid_valid;

  pipe_slot #(
    .W      (PAY_W),
    .CTRL_W (MEM_WB_CTRL_W)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (skid_load),
    .clear (skid_clear),
    .flush (flush),
    .d     (in_pay),
    .valid (skid_valid),
    .q     (skid_q)
  );
`else
  assign in_ready  = main_free;
  assign main_load = accept;
  assign main_d    = in_pay;
`endif

  // Main register: a consumed beat empties the slot unless a new one loads the same edge.
  pipe_slot #(
    .W      (PAY_W),
    .CTRL_W (MEM_WB_CTRL_W)
  ) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (main_load),
    .clear (out_ready),
    .flush (flush),
    .d     (main_d),
    .valid (main_valid),
    .q     (main_q)
  );

  assign out_valid = main_valid;
  assign {out_wb_en, out_mem_r_en, out_alu_result, out_mem_rd_data,
          out_pc, out_instr, out_dest} = main_q;

  // Count cycles the WB side holds off a presented beat; stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// Scoreboard bench for mem_wb_pipe_stage: the model is a queue of beats held by
// the stage plus a saturating stall count. Build with MEM_WB_SKID_EN to test the
// skid variant.
module tb_mem_wb_pipe_stage;
  import cpu_pipe_pkg::*;

  localparam int DATA_W    = DATA_W_DEF;
  localparam int DEST_W    = DEST_W_DEF;
  localparam int STALL_W   = 4;
  localparam int STALL_MAX = (1 << STALL_W) - 1;
`ifdef MEM_WB_SKID_EN
  localparam int EXTRA_EXP = 1;
`else
  localparam int EXTRA_EXP = 0;
`endif

  logic               clk;
  logic               rst_n;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic               in_wb_en;
  logic               in_mem_r_en;
  logic [DATA_W-1:0]  in_alu_result;
  logic [DATA_W-1:0]  in_mem_rd_data;
  logic [DATA_W-1:0]  in_pc;
  logic [DATA_W-1:0]  in_instr;
  logic [DEST_W-1:0]  in_dest;
  logic               out_valid;
  logic               out_ready;
  logic               out_wb_en;
  logic               out_mem_r_en;
  logic [DATA_W-1:0]  out_alu_result;
  logic [DATA_W-1:0]  out_mem_rd_data;
  logic [DATA_W-1:0]  out_pc;
  logic [DATA_W-1:0]  out_instr;
  logic [DEST_W-1:0]  out_dest;
  logic [STALL_W-1:0] stall_cnt;

  mem_wb_pipe_stage #(
    .DATA_W  (DATA_W),
    .DEST_W  (DEST_W),
    .STALL_W (STALL_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_wb_en        (in_wb_en),
    .in_mem_r_en     (in_mem_r_en),
    .in_alu_result   (in_alu_result),
    .in_mem_rd_data  (in_mem_rd_data),
    .in_pc           (in_pc),
    .in_instr        (in_instr),
    .in_dest         (in_dest),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_wb_en       (out_wb_en),
    .out_mem_r_en    (out_mem_r_en),
    .out_alu_result  (out_alu_result),
    .out_mem_rd_data (out_mem_rd_data),
    .out_pc          (out_pc),
    .out_instr       (out_instr),
    .out_dest        (out_dest),
    .stall_cnt       (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model + monitor ----------------
  mem_wb_payload_t held_q[$];
  int              exp_stall = 0;

  function automatic mem_wb_payload_t in_payload();
    return {in_wb_en, in_mem_r_en, in_alu_result, in_mem_rd_data, in_pc, in_instr, in_dest};
  endfunction

  function automatic mem_wb_payload_t out_payload();
    return {out_wb_en, out_mem_r_en, out_alu_result, out_mem_rd_data, out_pc, out_instr, out_dest};
  endfunction

  // Inputs change just after posedge; the negedge sees the values for the coming edge.
  always @(negedge clk) begin
    bit              exp_valid;
    bit              exp_ready;
    mem_wb_payload_t exp_beat;
    if (!rst_n) begin
      held_q.delete();
      exp_stall = 0;
    end else begin
      exp_valid = held_q.size() > 0;
`ifdef MEM_WB_SKID_EN
      exp_ready = held_q.size() < 2;
`else
      exp_ready = (held_q.size() == 0) || out_ready;
`endif
      check("out_valid", out_valid, exp_valid);
      check("in_ready", in_ready, exp_ready);
      check("stall_cnt", stall_cnt, exp_stall);
      if (!out_valid) check("wb_gate", out_wb_en, 1'b0);
      if (flush) begin
        held_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          check("beat_expected", held_q.size() > 0, 1'b1);
          if (held_q.size() > 0) begin
            exp_beat = held_q.pop_front();
            check("out_payload", out_payload(), exp_beat);
          end
        end
        if (in_valid && in_ready) held_q.push_back(in_payload());
      end
      if (exp_valid && !out_ready && exp_stall < STALL_MAX) exp_stall++;
    end
  end

  // ---------------- driver ----------------
  function automatic mem_wb_payload_t rand_beat();
    mem_wb_payload_t b;
    b.wb_en       = 1'($urandom_range(0, 1));
    b.mem_r_en    = 1'($urandom_range(0, 1));
    b.alu_result  = $urandom;
    b.mem_rd_data = $urandom;
    b.pc          = $urandom;
    b.instr       = $urandom;
    b.dest        = DEST_W'($urandom_range(0, (1 << DEST_W) - 1));
    return b;
  endfunction

  task automatic present(input mem_wb_payload_t b);
    {in_wb_en, in_mem_r_en, in_alu_result, in_mem_rd_data, in_pc, in_instr, in_dest} = b;
    in_valid = 1'b1;
  endtask

  task automatic tick(output bit acc);
    @(negedge clk);
    acc = in_valid && in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input mem_wb_payload_t b);
    bit acc = 1'b0;
    present(b);
    for (int i = 0; i < 50 && !acc; i++) tick(acc);
    in_valid = 1'b0;
    check("send_accepted", acc, 1'b1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) tick(acc);
  endtask

  initial begin
    mem_wb_payload_t b;
    bit acc;
    int extra;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    present(rand_beat());
    in_valid = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_wb_en", out_wb_en, 1'b0);
    check("rst_stall_cnt", stall_cnt, '0);
    check("rst_out_alu", out_alu_result, '0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_rst", in_ready, 1'b1);

    // Streaming: 8 back-to-back beats, dest 1..8
    out_ready = 1'b1;
    for (int d = 1; d <= 8; d++) begin
      b = rand_beat();
      b.dest = DEST_W'(d);
      send(b);
    end
    idle(3);

    // Reset mid-stream with a beat held on the output
    out_ready = 1'b0;
    b = rand_beat();
    b.wb_en = 1'b1;
    send(b);
    idle(2);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_wb_en", out_wb_en, 1'b0);
    check("midrst_stall_cnt", stall_cnt, '0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_midrst", in_ready, 1'b1);

    // Backpressure: hold 0xDEADBEEF for 5 stalled cycles while offering more beats
    b = rand_beat();
    b.alu_result = 32'hDEADBEEF;
    send(b);
    extra = 0;
    present(rand_beat());
    for (int i = 0; i < 5; i++) begin
      tick(acc);
      if (acc) begin
        extra++;
        present(rand_beat());
      end
    end
    check("bp_alu_held", out_alu_result, 32'hDEADBEEF);
    check("bp_stall_cnt", stall_cnt, 4'd5);
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_extra_beats", extra, EXTRA_EXP);

    // Simultaneous consume and accept: no bubbles, older beats drain first
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(acc);
      if (acc) present(rand_beat());
      check("no_bubble", out_valid, 1'b1);
    end
    in_valid = 1'b0;
    idle(3);

    // Flush with a held beat and a beat on the input; both must vanish
    out_ready = 1'b0;
    b = rand_beat();
    b.wb_en = 1'b1;
    send(b);
    b = rand_beat();
    b.wb_en = 1'b1;
    present(b);
    flush = 1'b1;
    tick(acc);
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_out_wb_en", out_wb_en, 1'b0);
    out_ready = 1'b1;
    idle(4);

    // Saturation: 20+ stalled cycles pin the 4-bit counter at 15
    out_ready = 1'b0;
    send(rand_beat());
    idle(20);
    check("sat_stall_cnt", stall_cnt, 4'd15);
    idle(5);
    check("sat_stall_hold", stall_cnt, 4'd15);
    out_ready = 1'b1;
    idle(3);

    // Randomized traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      if (flush) out_ready = 1'b0;
      if (!in_valid && $urandom_range(0, 1) == 1) present(rand_beat());
      tick(acc);
      flush = 1'b0;
      if (acc) begin
        if ($urandom_range(0, 3) != 0) present(rand_beat());
        else in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
